mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified-memory port of the RISC-V core between the instruction-fetch path and the load/store path. It arbitrates between the two requesters and drives the memory request until the memory answers or a watchdog expires. It returns the read data or an error to the requester that owns the access. It sits between the fetch/LSU datapath and the memory model, under the top-level Control FSM.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- TIMEOUT_CYC, 64, maximum cycles to wait for mem_ready (must be ≥1, 8-bit counter is sufficient up to 255)
- STREAK_MAX, 4, consecutive contested data grants allowed before fetch is forced (used only with ARB_FAIR_EN)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_valid  out  1  one-cycle completion pulse to fetch
- if_err  out  1  one-cycle timeout pulse to fetch
- if_rdata  out  DATA_W  fetched word, valid with if_valid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt, d_valid, d_err  out  1 each  as for fetch
- d_rdata  out  DATA_W  load data, valid with d_valid
- mem_req  out  1  request to memory, held until mem_ready or timeout
- mem_we, mem_addr, mem_wdata, mem_be  out  command to memory, stable while mem_req=1
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ready
- mem_ready  in  1  memory completion
- busy  out  1  high while in BUSY

## Operation
- FSM states: IDLE, BUSY.
- IDLE, no request: stay in IDLE and keep all outputs low.
- IDLE, one or both requests:
  - Choose the owner: data wins by default.
  - Latch the owner's command into the mem_* registers. Fetch commands are mem_we=0, mem_be=all ones, mem_wdata=0.
  - At the next edge: go to BUSY, set mem_req=1, pulse the owner's gnt, clear the watchdog counter.
- BUSY, per cycle:
  - Increment the counter.
  - mem_ready=1: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), pulse the owner's valid next cycle, drop mem_req, go to IDLE.
  - Otherwise, if the counter reaches TIMEOUT_CYC: drop mem_req, pulse the owner's err next cycle, go to IDLE.
  - mem_ready and timeout in the same cycle: mem_ready wins; valid pulses, err does not.
- Requests arriving in BUSY are ignored until IDLE. A requester still holding req sees no gnt.
- Only one of gnt/valid/err is pulsed per requester per cycle. The other requester's outputs stay 0.
- Reset mid-transaction: the in-flight access is abandoned, with no valid/err pulse and mem_req low from the next cycle.

## Timing
- Reset values: state IDLE, all *_gnt/*_valid/*_err 0, mem_req 0, mem_* command 0, rdata registers 0, busy 0, counters 0.
- Request seen in IDLE at edge N: gnt, mem_req and busy are high from N+1. gnt is high for exactly one cycle.
- mem_ready sampled high at edge M: mem_req and busy are low and valid is high from M+1 for one cycle.
- Minimum access: 3 cycles from req to valid with mem_ready tied high. Back-to-back grants are spaced ≥2 cycles apart; the IDLE cycle after completion may already grant.
- Timeout: err asserts TIMEOUT_CYC+1 cycles after gnt.

## Configuration
- ARB_FAIR_EN defined:
  - A streak counter (0..STREAK_MAX) increments on each data grant issued while if_req=1.
  - When streak==STREAK_MAX and both requests are present, fetch wins.
  - The streak clears on any fetch grant, and when if_req=0 at a data grant.
- ARB_FAIR_EN undefined: strict data priority, no streak counter, STREAK_MAX ignored.

## Test plan
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ready high 2 cycles after mem_req, mem_rdata=0x0000_0013 -> if_gnt one cycle; if_valid with if_rdata=0x13; mem_we=0, mem_be=0xF.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3 -> mem_* carry exactly those values while mem_req=1; d_valid after mem_ready; d_rdata unchanged.
- Contention: if_req and d_req held continuously, mem_ready immediate.
  - Without ARB_FAIR_EN: only d_gnt occurs.
  - With it, STREAK_MAX=4: grant order D,D,D,D,F repeating.
- Timeout: mem_ready held 0, TIMEOUT_CYC=8 -> d_err pulse 9 cycles after d_gnt, no d_valid, mem_req low, next request granted normally.
- Ready-at-timeout: mem_ready asserted in the same cycle the counter hits TIMEOUT_CYC -> valid pulses, err stays 0.
- Reset mid-access: rst=0 for one cycle while busy=1 -> next cycle all outputs 0, no valid/err; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified-memory port between instruction fetch and the
// load/store unit. One access is in flight at a time: the winner's command is
// latched into the mem_* registers, held until mem_ready or a watchdog timeout,
// and the result is returned to the requester that owns the access.
//
// Build option: define ARB_FAIR_EN to add a data-grant streak counter that
// forces a fetch grant after STREAK_MAX consecutive contested data grants.
// Without it data has strict priority over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int STREAK_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_valid,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // The watchdog is a plain 8-bit counter; the limit is compared at that width.
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

  // Reject configurations the 8-bit watchdog or the streak counter cannot represent.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || STREAK_MAX < 0) begin : g_bad_cfg
    $error("mem_port_arbiter: TIMEOUT_CYC must be 1..255 and STREAK_MAX >= 0");
  end

  logic [0:0]        state_q, state_d;
  logic              owner_is_data_q, owner_is_data_d;
  logic [7:0]        wdog_q, wdog_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;

  logic              d_gnt_q, d_gnt_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // High when data would be chosen in IDLE (only meaningful with a request present).
  logic              pick_data;

`ifdef ARB_FAIR_EN
  localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

  logic [SW-1:0] streak_q, streak_d;

  // Data keeps priority until it has won STREAK_MAX contested grants in a row.
  assign pick_data = d_req && !(if_req && (streak_q == SW'(STREAK_MAX)));

  // Count data grants issued while fetch was waiting; any fetch grant, or a data
  // grant with fetch idle, starts the streak over.
  always_comb begin
    streak_d = streak_q;
    if (state_q == S_IDLE && (if_req || d_req)) begin
      if (pick_data) begin
        streak_d = if_req ? (streak_q + 1'b1) : '0;
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  // Strict data priority.
  assign pick_data = d_req;
`endif

  // Next-state logic for the access FSM, memory command and requester responses.
  always_comb begin
    state_d         = state_q;
    owner_is_data_d = owner_is_data_q;
    wdog_d          = wdog_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    if_rdata_d      = if_rdata_q;
    d_rdata_d       = d_rdata_q;
    // gnt/valid/err are single-cycle pulses: low unless set below
    if_gnt_d        = 1'b0;
    if_valid_d      = 1'b0;
    if_err_d        = 1'b0;
    d_gnt_d         = 1'b0;
    d_valid_d       = 1'b0;
    d_err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d   = S_BUSY;
          mem_req_d = 1'b1;
          wdog_d    = '0;
          if (pick_data) begin
            owner_is_data_d = 1'b1;
            d_gnt_d         = 1'b1;
            mem_we_d        = d_we;
            mem_addr_d      = d_addr;
            mem_wdata_d     = d_wdata;
            mem_be_d        = d_be;
          end else begin
            owner_is_data_d = 1'b0;
            if_gnt_d        = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = if_addr;
            mem_wdata_d     = '0;
            mem_be_d        = '1;
          end
        end else begin
          // nothing pending: park the memory command at zero
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
        end
      end

      S_BUSY: begin
        wdog_d = wdog_q + 8'd1;
        if (mem_ready) begin
          // a completion takes precedence over a watchdog expiry in the same cycle
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (owner_is_data_q) begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (wdog_q == TIMEOUT_VAL) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (owner_is_data_q) begin
            d_err_d = 1'b1;
          end else begin
            if_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, command and response registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      owner_is_data_q <= 1'b0;
      wdog_q          <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      if_gnt_q        <= 1'b0;
      if_valid_q      <= 1'b0;
      if_err_q        <= 1'b0;
      if_rdata_q      <= '0;
      d_gnt_q         <= 1'b0;
      d_valid_q       <= 1'b0;
      d_err_q         <= 1'b0;
      d_rdata_q       <= '0;
    end else begin
      state_q         <= state_d;
      owner_is_data_q <= owner_is_data_d;
      wdog_q          <= wdog_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      if_gnt_q        <= if_gnt_d;
      if_valid_q      <= if_valid_d;
      if_err_q        <= if_err_d;
      if_rdata_q      <= if_rdata_d;
      d_gnt_q         <= d_gnt_d;
      d_valid_q       <= d_valid_d;
      d_err_q         <= d_err_d;
      d_rdata_q       <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q == S_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Each access pushes its expected completion (owner, valid/err, rdata, latency
// from grant) to a queue; a negedge monitor pops and compares on every
// valid/err pulse. Builds with or without ARB_FAIR_EN.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOUT = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_valid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic          d_gnt, d_valid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TOUT), .STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          is_err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  bit          prev_gnt = 1'b0;
  logic [31:0] model_d_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant width, then pop-and-compare on every completion pulse.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] got_f, exp_f;
    if ((if_gnt || d_gnt) && prev_gnt) check("gnt_width", 1, 0);
    prev_gnt = if_gnt || d_gnt;
    if (if_gnt || d_gnt) last_gnt_cyc = cyc;
    got_f = {if_valid, if_err, d_valid, d_err};
    if (got_f != 4'b0000) begin
      if (sb.size() == 0) begin
        check("spurious_evt", got_f, 0);
      end else begin
        e = sb.pop_front();
        exp_f = e.is_d ? (e.is_err ? 4'b0001 : 4'b0010) : (e.is_err ? 4'b0100 : 4'b1000);
        check("evt_flags", got_f, exp_f);
        check("evt_latency", cyc - last_gnt_cyc, e.lat);
        if (!e.is_err) check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        check("mem_req_after", mem_req, 0);
        check("busy_after", busy, 0);
        $display("txn %s %s rdata=0x%08h lat=%0d", e.is_d ? "D" : "F",
                 e.is_err ? "err" : "valid", e.is_d ? d_rdata : if_rdata, cyc - last_gnt_cyc);
      end
    end
  end

  // Wait (bounded) until the scoreboard has drained.
  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One access; delay<0 means memory never answers (watchdog path).
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] rdata, input int delay);
    exp_t e;
    int   waited;
    bit   found;
    e.is_d   = is_d;
    e.is_err = (delay < 0);
    e.lat    = (delay < 0) ? TOUT + 1 : delay + 1;
    if (is_d && we) e.rdata = model_d_rdata;
    else            e.rdata = rdata;
    if (is_d && !we && delay >= 0) model_d_rdata = rdata;
    sb.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin found = 1'b1; waited = i; break; end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    if (!found) begin
      check("gnt_missing", 0, 1);
      sb.delete();
      return;
    end
    check("gnt_wait", waited, 0);
    check("gnt_own", is_d ? d_gnt : if_gnt, 1);
    check("gnt_other", is_d ? if_gnt : d_gnt, 0);
    check("mem_req_on", mem_req, 1);
    check("busy_on", busy, 1);
    check("mem_we", mem_we, is_d ? we : 1'b0);
    check("mem_addr", mem_addr, addr);
    check("mem_wdata", mem_wdata, is_d ? wdata : 32'h0);
    check("mem_be", mem_be, is_d ? be : 4'hF);
    if (delay >= 0) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("mem_req_hold", mem_req, 1);
        check("mem_addr_hold", mem_addr, addr);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(posedge clk);
      #1 mem_ready = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
    end
    drain();
  endtask

  initial begin
    bit          is_d, we;
    logic [31:0] rd;
    int          ngnt;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_gnts", {if_gnt, d_gnt}, 0);
    check("rst_vld_err", {if_valid, if_err, d_valid, d_err}, 0);
    check("rst_mem_cmd", {mem_we, mem_be, mem_addr, mem_wdata[15:0]}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, memory answers two cycles in.
    access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0013, 2);
    // Load, then a store that must leave d_rdata alone.
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'hA5A5_1234, 0);
    access(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'h1111_1111, 1);
    check("store_keeps_rdata", d_rdata, 32'hA5A5_1234);
    // Watchdog expiry, then a normal request.
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'h0, -1);
    access(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0000_0093, 0);
    // Ready in the very cycle the watchdog hits its limit.
    access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 32'h7777_0001, TOUT);

    // Contention with mem_ready tied high.
    mem_ready = 1'b1;
    mem_rdata = 32'hC0FF_EE00;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
`ifdef ARB_FAIR_EN
      e.is_d = ((i % (SMAX + 1)) != SMAX);
`else
      e.is_d = 1'b1;
`endif
      e.is_err = 1'b0;
      e.rdata  = 32'hC0FF_EE00;
      e.lat    = 1;
      sb.push_back(e);
    end
    model_d_rdata = 32'hC0FF_EE00;
    if_addr = 32'h0000_0080; d_addr = 32'h0000_0400; d_we = 1'b0; d_be = 4'hF;
    if_req = 1'b1; d_req = 1'b1;
    ngnt = 0;
    for (int i = 0; i < 200 && ngnt < 10; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) ngnt++;
    end
    if_req = 1'b0; d_req = 1'b0;
    check("contention_gnts", ngnt, 10);
    drain();
    mem_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of an access.
    model_d_rdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_be = 4'hF;
    for (int i = 0; i < 10 && !d_gnt; i++) @(negedge clk);
    d_req = 1'b0;
    check("mid_gnt", d_gnt, 1);
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulses", {if_gnt, if_valid, if_err, d_gnt, d_valid, d_err}, 0);
    check("mid_rst_cmd", {mem_we, mem_be, mem_addr}, 0);
    check("mid_rst_rdata", d_rdata, 0);
    repeat (TOUT + 4) @(negedge clk);
    access(1'b1, 1'b0, 32'h0000_0504, 32'h0, 4'hF, 32'h5050_0A0A, 1);

    // A few random accesses.
    for (int k = 0; k < 6; k++) begin
      is_d = $urandom_range(0, 1);
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      rd   = $urandom;
      access(is_d, we, {$urandom_range(0, 1023), 2'b00}, $urandom, 4'($urandom_range(1, 15)),
             rd, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
